mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sequences each access: it arbitrates, drives the memory port, counts out the fixed read latency and routes read data back to the owning requester.
- Generates the stall signals that the pipeline control logic consumes.
- DM has priority by default. An IF starvation counter forces an IF grant after a bounded wait.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one main-memory port between the instruction-fetch requester (IF) and
// the load/store requester (DM). Arbitration happens combinationally in IDLE;
// the winner drives the memory port in the same cycle. A read moves the block
// to WAIT, where it counts out the fixed read latency and then routes
// mem_rdata back to whichever requester owns the read. Writes complete in the
// grant cycle, so back-to-back writes run one per cycle.
//
// DM wins ties unless IF has been denied for STARVE_LIMIT consecutive
// requesting cycles, in which case IF wins the next arbitration.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   if_req/if_addr         fetch read request and word address
//   if_grant               fetch request accepted this cycle
//   if_rvalid/if_rdata     fetch read data return
//   if_stall               if_req & ~if_grant
//   dm_req/dm_we/dm_addr   data request, write flag, word address
//   dm_wdata               data write data
//   dm_grant               data request accepted this cycle
//   dm_rvalid/dm_rdata     data read data return
//   dm_stall               dm_req & ~dm_grant
//   mem_en/mem_we          memory access strobe and write enable
//   mem_addr/mem_wdata     memory address and write data
//   mem_rdata              memory read data, valid READ_LATENCY cycles after mem_en

module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_grant,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // FSM encoding
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  // Owner encoding for the outstanding read
  localparam logic OwnerIf = 1'b0;
  localparam logic OwnerDm = 1'b1;

  localparam logic [CNT_W-1:0] LatLoad   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             owner_q, owner_d;

  logic arb_en;
  logic if_win;
  logic dm_win;
  logic rd_grant;
  logic rd_done;

  // Arbitration and read completion. Everything is gated by rst so that no
  // grant or rvalid can leak out while reset is held, even before the first
  // clock edge has cleared the state registers.
  always_comb begin
    arb_en   = ~rst & (state_q == StIdle);
    if_win   = arb_en & if_req & (~dm_req | (starve_q >= StarveLim));
    dm_win   = arb_en & dm_req & ~if_win;
    rd_grant = if_win | (dm_win & ~dm_we);
    rd_done  = ~rst & (state_q == StWait) & (lat_q == '0);
  end

  // Requester-facing outputs
  always_comb begin
    if_grant  = if_win;
    dm_grant  = dm_win;
    if_stall  = if_req & ~if_win;
    dm_stall  = dm_req & ~dm_win;
    if_rvalid = rd_done & (owner_q == OwnerIf);
    dm_rvalid = rd_done & (owner_q == OwnerDm);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

  // Memory port: driven by the winner in the grant cycle, quiet otherwise
  always_comb begin
    mem_en    = if_win | dm_win;
    mem_we    = dm_win & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_win) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_win) begin
      mem_addr  = if_addr;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    owner_d = owner_q;

    unique case (state_q)
      StIdle: begin
        if (rd_grant) begin
          state_d = StWait;
          lat_d   = LatLoad;
          owner_d = dm_win ? OwnerDm : OwnerIf;
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          state_d = StIdle;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Starvation counter: counts every denied IF-request cycle, WAIT included,
  // and clears as soon as IF is granted or stops asking.
  always_comb begin
    starve_d = '0;
    if (if_req & ~if_win) begin
      starve_d = (starve_q == CntMax) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      starve_q <= '0;
      owner_q  <= OwnerIf;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A reference model predicts, per
// cycle, who is granted, what the memory port carries and when read data
// returns; expectations are queued and a negedge monitor pops and compares.

module tb_mem_port_arbiter;

  localparam int RL     = 2;
  localparam int SL     = 4;
  localparam int CW     = 4;
  localparam int SATMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_grant, if_rvalid, if_stall;
  logic        dm_grant, dm_rvalid, dm_stall;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Memory read data is a known function of the cycle, so the expected return
  // value for a read is simply the value on the bus in its return cycle.
  function automatic logic [31:0] data_of(input int c);
    return (32'(c) * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_rdata = data_of(cyc);

  mem_port_arbiter #(
    .READ_LATENCY(RL),
    .STARVE_LIMIT(SL),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_grant (if_grant),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_grant (dm_grant),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .dm_stall (dm_stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int  cyc;
    bit  ifs;
    bit  dms;
    bit  en;
    bit  we;
  } cyc_t;

  typedef struct {
    int          cyc;
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    bit          is_dm;
    logic [31:0] data;
  } rd_t;

  cyc_t cyc_q[$];
  gnt_t gnt_q[$];
  rd_t  rd_q[$];

  // Reference model state: one outstanding read at most
  bit m_pend    = 1'b0;
  bit m_pend_dm = 1'b0;
  int m_due     = 0;
  int m_starve  = 0;

  // Requester intents (held until the model says they were granted)
  bit          if_want = 1'b0;
  logic [31:0] if_a    = '0;
  bit          dm_want = 1'b0;
  bit          dm_w    = 1'b0;
  logic [31:0] dm_a    = '0;
  logic [31:0] dm_d    = '0;

  task automatic chk(input bit ok, input string name, input string det);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: %s", name, cyc, det);
    end
  endtask

  // Drive one cycle of inputs and predict the DUT's response to it
  task automatic tick(input bit r);
    bit   iw;
    bit   dw;
    cyc_t ce;
    gnt_t ge;
    rd_t  re;
    iw = 1'b0;
    dw = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst      = r;
    if_req   = if_want;
    if_addr  = if_a;
    dm_req   = dm_want;
    dm_we    = dm_w;
    dm_addr  = dm_a;
    dm_wdata = dm_d;
    if (r) begin
      m_pend   = 1'b0;
      m_starve = 0;
    end else begin
      if (!m_pend) begin
        iw = if_want && (!dm_want || m_starve >= SL);
        dw = dm_want && !iw;
      end
      if (m_pend && m_due == cyc) begin
        re.cyc   = cyc;
        re.is_dm = m_pend_dm;
        re.data  = data_of(cyc);
        rd_q.push_back(re);
        m_pend = 1'b0;
      end
      if (iw || dw) begin
        ge.cyc   = cyc;
        ge.is_dm = dw;
        ge.we    = dw && dm_w;
        ge.addr  = dw ? dm_a : if_a;
        ge.wdata = dm_d;
        gnt_q.push_back(ge);
        if (iw || !dm_w) begin
          m_pend    = 1'b1;
          m_pend_dm = dw;
          m_due     = cyc + RL;
        end
      end
      if (if_want && !iw) m_starve = (m_starve < SATMAX) ? m_starve + 1 : SATMAX;
      else                m_starve = 0;
    end
    ce.cyc = cyc;
    ce.ifs = if_want && !iw;
    ce.dms = dm_want && !dw;
    ce.en  = iw || dw;
    ce.we  = dw && dm_w;
    cyc_q.push_back(ce);
    if (iw) if_want = 1'b0;
    if (dw) dm_want = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0);
  endtask

  // Monitor
  cyc_t mc;
  gnt_t mg;
  rd_t  mr;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk(mc.cyc == cyc && if_stall === mc.ifs && dm_stall === mc.dms &&
          mem_en === mc.en && mem_we === mc.we, "cycle",
          $sformatf("got if_stall=%b dm_stall=%b mem_en=%b mem_we=%b exp %b %b %b %b",
                    if_stall, dm_stall, mem_en, mem_we, mc.ifs, mc.dms, mc.en, mc.we));
    end
    if (if_grant === 1'b1 || dm_grant === 1'b1) begin
      if (gnt_q.size() == 0) begin
        chk(1'b0, "spurious_grant",
            $sformatf("got if_grant=%b dm_grant=%b exp none", if_grant, dm_grant));
      end else begin
        mg = gnt_q.pop_front();
        chk(mg.cyc == cyc &&
            (mg.is_dm ? (dm_grant === 1'b1 && if_grant === 1'b0)
                      : (if_grant === 1'b1 && dm_grant === 1'b0)) &&
            mem_addr === mg.addr && mem_we === mg.we &&
            (!mg.we || mem_wdata === mg.wdata), "grant",
            $sformatf("got ifg=%b dmg=%b addr=%h we=%b wd=%h exp cyc=%0d dm=%b addr=%h we=%b wd=%h",
                      if_grant, dm_grant, mem_addr, mem_we, mem_wdata,
                      mg.cyc, mg.is_dm, mg.addr, mg.we, mg.wdata));
      end
    end
    if (if_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        chk(1'b0, "spurious_rvalid",
            $sformatf("got if_rvalid=%b dm_rvalid=%b exp none", if_rvalid, dm_rvalid));
      end else begin
        mr = rd_q.pop_front();
        chk(mr.cyc == cyc &&
            (mr.is_dm ? (dm_rvalid === 1'b1 && if_rvalid === 1'b0 && dm_rdata === mr.data)
                      : (if_rvalid === 1'b1 && dm_rvalid === 1'b0 && if_rdata === mr.data)),
            "rvalid",
            $sformatf("got ifv=%b dmv=%b ifd=%h dmd=%h exp cyc=%0d dm=%b data=%h",
                      if_rvalid, dm_rvalid, if_rdata, dm_rdata, mr.cyc, mr.is_dm, mr.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp $finish");
    $fatal(1, "watchdog");
  end

  int wk;

  initial begin
    rst      = 1'b1;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    if_addr  = '0;
    dm_addr  = '0;
    dm_wdata = '0;

    tick(1'b1);
    tick(1'b1);

    // IF only
    if_want = 1'b1; if_a = 32'h10;
    run(4);

    // Both requesting, DM read wins, IF follows after the read returns
    dm_want = 1'b1; dm_w = 1'b0; dm_a = 32'h20;
    if_want = 1'b1; if_a = 32'h30;
    run(8);

    // Continuous DM writes against a held IF request
    if_want = 1'b1; if_a = 32'h50;
    wk = 0;
    repeat (8) begin
      if (!dm_want) begin
        dm_want = 1'b1; dm_w = 1'b1; dm_a = 32'h40 + 32'(wk); dm_d = $urandom;
        wk++;
      end
      tick(1'b0);
    end
    dm_want = 1'b0;
    run(6);

    // Write then read, back to back
    dm_want = 1'b1; dm_w = 1'b1; dm_a = 32'h5; dm_d = 32'h55;
    tick(1'b0);
    dm_want = 1'b1; dm_w = 1'b0; dm_a = 32'h5;
    run(4);

    // Reset in the cycle after a read grant
    dm_want = 1'b1; dm_w = 1'b0; dm_a = 32'h60;
    tick(1'b0);
    tick(1'b1);
    if_want = 1'b1; if_a = 32'h70;
    run(4);

    // Nothing requested
    run(3);

    // Randomized traffic with withdrawals and occasional reset
    repeat (3000) begin
      if (!if_want) begin
        if ($urandom_range(2) == 0) begin if_want = 1'b1; if_a = $urandom; end
      end else if ($urandom_range(15) == 0) begin
        if_want = 1'b0;
      end
      if (!dm_want) begin
        if ($urandom_range(2) == 0) begin
          dm_want = 1'b1; dm_w = $urandom_range(1) == 1; dm_a = $urandom; dm_d = $urandom;
        end
      end else if ($urandom_range(15) == 0) begin
        dm_want = 1'b0;
      end
      tick($urandom_range(96) == 0);
    end

    if_want = 1'b0;
    dm_want = 1'b0;
    run(RL + 3);

    @(negedge clk);
    #1;
    chk(cyc_q.size() == 0 && gnt_q.size() == 0 && rd_q.size() == 0, "drain",
        $sformatf("got pending cyc=%0d gnt=%0d rd=%0d exp 0 0 0",
                  cyc_q.size(), gnt_q.size(), rd_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
